parking_slot_mgr: RTL and testbench

- Downstream of the parking gate controller. Consumes the gate's back-sensor signal (`bksens`, car has passed the gate) and the vehicle number presented with it.
- Allocates the lowest-numbered free slot among 16 and stores the vehicle number against it.
- Handles exit requests by vehicle lookup.
- Publishes occupancy count and full/empty status back to the gate logic and the display.

---
 rtl/parking_slot_mgr.sv | 138 +++++++++++++
 tb/tb_parking_slot_mgr.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/parking_slot_mgr.sv
// parking_slot_mgr: assigns the lowest free of 16 slots on a gate entry edge and frees slots on exit by vehicle lookup.
// Every lookup is a fixed 16-cycle scan, so the response latency does not depend on occupancy.
module parking_slot_mgr #(
    parameter int n     = 4,
    parameter int SLOTS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bksens,
    input  logic [n-1:0] vn,
    input  logic         exit_req,
    input  logic [n-1:0] exit_vn,
    output logic         entry_ok,
    output logic         entry_rej,
    output logic [3:0]   slot_id,
    output logic         exit_ok,
    output logic         exit_err,
    output logic [4:0]   count,
    output logic         full,
    output logic         empty,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
    state_t                  state;
    logic [SLOTS-1:0]        occ;
    logic [SLOTS-1:0][n-1:0] vns;
    logic                    bksens_q, bk_edge, op_exit, pend, hit, free_seen;
    logic                    match, hit_nx, free_nx;
    logic [n-1:0]            cur_vn, pend_vn;
    logic [3:0]              idx, hit_idx, free_idx, hit_idx_nx, free_idx_nx;

    assign bk_edge     = bksens & ~bksens_q;
    assign match       = occ[idx] && vns[idx] == cur_vn;
    assign hit_nx      = hit | match;
    assign hit_idx_nx  = (match && !hit) ? idx : hit_idx;
    assign free_nx     = free_seen | ~occ[idx];
    assign free_idx_nx = (!occ[idx] && !free_seen) ? idx : free_idx;

    // The verdict is registered on the last scan cycle, so pulses are visible during RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            occ       <= '0;
            vns       <= '0;
            bksens_q  <= 1'b0;
            op_exit   <= 1'b0;
            pend      <= 1'b0;
            pend_vn   <= '0;
            cur_vn    <= '0;
            idx       <= '0;
            hit       <= 1'b0;
            free_seen <= 1'b0;
            hit_idx   <= '0;
            free_idx  <= '0;
            entry_ok  <= 1'b0;
            entry_rej <= 1'b0;
            exit_ok   <= 1'b0;
            exit_err  <= 1'b0;
            slot_id   <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            busy      <= 1'b0;
        end else begin
            bksens_q  <= bksens;
            entry_ok  <= 1'b0;
            entry_rej <= 1'b0;
            exit_ok   <= 1'b0;
            exit_err  <= 1'b0;
            if (state != IDLE && exit_req && !pend) begin
                pend    <= 1'b1;
                pend_vn <= exit_vn;
            end
            if (state == IDLE) begin
                idx       <= '0;
                hit       <= 1'b0;
                free_seen <= 1'b0;
                if (bk_edge) begin
                    if (exit_req && !pend) begin
                        pend    <= 1'b1;
                        pend_vn <= exit_vn;
                    end
                    if (full) begin
                        entry_rej <= 1'b1;
                    end else begin
                        cur_vn  <= vn;
                        op_exit <= 1'b0;
                        state   <= SCAN;
                        busy    <= 1'b1;
                    end
                end else if (exit_req || pend) begin
                    cur_vn  <= pend ? pend_vn : exit_vn;
                    op_exit <= 1'b1;
                    state   <= SCAN;
                    busy    <= 1'b1;
                    pend    <= pend & exit_req;
                    pend_vn <= exit_vn;
                end
            end else if (state == SCAN) begin
                idx       <= idx + 4'd1;
                hit       <= hit_nx;
                free_seen <= free_nx;
                hit_idx   <= hit_idx_nx;
                free_idx  <= free_idx_nx;
                if (idx == 4'd15) begin
                    state <= RESP;
                    if (!op_exit) begin
                        if (hit_nx || !free_nx || count == 5'd16) begin
                            entry_rej <= 1'b1;
                        end else begin
                            occ[free_idx_nx] <= 1'b1;
                            vns[free_idx_nx] <= cur_vn;
                            slot_id          <= free_idx_nx;
                            entry_ok         <= 1'b1;
                            count            <= count + 5'd1;
                            full             <= count == 5'd15;
                            empty            <= 1'b0;
                        end
                    end else if (hit_nx) begin
                        occ[hit_idx_nx] <= 1'b0;
                        slot_id         <= hit_idx_nx;
                        exit_ok         <= 1'b1;
                        full            <= 1'b0;
                        if (count != 5'd0) begin
                            count <= count - 5'd1;
                            empty <= count == 5'd1;
                        end
                    end else begin
                        exit_err <= 1'b1;
                    end
                end
            end else begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_parking_slot_mgr.sv
// tb_parking_slot_mgr: directed entries/exits with a slot model; expected responses are queued at drive time
// and checked against each response pulse, including its arrival cycle.
module tb_parking_slot_mgr;
    logic       clk = 1'b0, rst_n = 1'b0, bksens = 1'b0, exit_req = 1'b0;
    logic [3:0] vn = '0, exit_vn = '0;
    logic       entry_ok, entry_rej, exit_ok, exit_err, full, empty, busy;
    logic [3:0] slot_id;
    logic [4:0] count;

    parking_slot_mgr #(.n(4), .SLOTS(16)) dut (
        .clk(clk), .rst_n(rst_n), .bksens(bksens), .vn(vn), .exit_req(exit_req), .exit_vn(exit_vn),
        .entry_ok(entry_ok), .entry_rej(entry_rej), .slot_id(slot_id), .exit_ok(exit_ok),
        .exit_err(exit_err), .count(count), .full(full), .empty(empty), .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] K_OK = 4'b1000, K_REJ = 4'b0100, K_XOK = 4'b0010, K_XERR = 4'b0001;

    typedef struct {
        logic [3:0] kind;
        logic [3:0] slot;
        int         due;
        int         cnt;
    } exp_t;

    exp_t       q[$];
    exp_t       e_m;
    int         cyc = 0, checks = 0, errors = 0;
    bit         mocc[16];
    logic [3:0] mvn[16];
    int         mcount = 0;
    logic [3:0] last_slot = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void push(input logic [3:0] k, input logic [3:0] s, input int due);
        exp_t e;
        e.kind = k;
        e.slot = s;
        e.due  = due;
        e.cnt  = mcount;
        q.push_back(e);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            mocc[i] = 1'b0;
            mvn[i]  = '0;
        end
        mcount    = 0;
        last_slot = '0;
    endfunction

    function automatic void model_entry(input logic [3:0] v, input int t);
        int f   = -1;
        bit dup = 1'b0;
        if (mcount == 16) begin
            push(K_REJ, last_slot, t + 1);
            return;
        end
        for (int i = 0; i < 16; i++) begin
            if (mocc[i] && mvn[i] == v) dup = 1'b1;
            if (!mocc[i] && f < 0) f = i;
        end
        if (dup) begin
            push(K_REJ, last_slot, t + 17);
        end else begin
            mocc[f]   = 1'b1;
            mvn[f]    = v;
            mcount++;
            last_slot = f[3:0];
            push(K_OK, last_slot, t + 17);
        end
    endfunction

    function automatic void model_exit(input logic [3:0] v, input int t);
        int f = -1;
        for (int i = 0; i < 16; i++)
            if (mocc[i] && mvn[i] == v && f < 0) f = i;
        if (f < 0) begin
            push(K_XERR, last_slot, t + 17);
        end else begin
            mocc[f]   = 1'b0;
            mcount--;
            last_slot = f[3:0];
            push(K_XOK, last_slot, t + 17);
        end
    endfunction

    always @(negedge clk) begin
        if (entry_ok | entry_rej | exit_ok | exit_err) begin
            chk("pulse_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e_m = q.pop_front();
                chk("pulse_kind", {entry_ok, entry_rej, exit_ok, exit_err}, e_m.kind);
                chk("slot_id", slot_id, e_m.slot);
                chk("pulse_cycle", cyc, e_m.due);
                chk("count", count, e_m.cnt);
                chk("full", full, e_m.cnt == 16);
                chk("empty", empty, e_m.cnt == 0);
            end
        end
    end

    task automatic do_entry(input logic [3:0] v);
        @(posedge clk); #1;
        bksens = 1'b1;
        vn     = v;
        model_entry(v, cyc);
        @(posedge clk); #1;
        bksens = 1'b0;
    endtask

    task automatic do_exit(input logic [3:0] v);
        @(posedge clk); #1;
        exit_req = 1'b1;
        exit_vn  = v;
        model_exit(v, cyc);
        @(posedge clk); #1;
        exit_req = 1'b0;
    endtask

    task automatic do_both(input logic [3:0] ve, input logic [3:0] vx);
        @(posedge clk); #1;
        bksens   = 1'b1;
        vn       = ve;
        exit_req = 1'b1;
        exit_vn  = vx;
        model_entry(ve, cyc);
        model_exit(vx, cyc + 18);
        @(posedge clk); #1;
        bksens   = 1'b0;
        exit_req = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("response_timeout", q.size(), 0);
        q.delete();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int fill[13] = '{0, 1, 2, 3, 4, 6, 8, 10, 11, 12, 13, 14, 15};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_slot", slot_id, 0);
        chk("rst_pulses", {entry_ok, entry_rej, exit_ok, exit_err}, 0);
        rst_n = 1'b1;

        do_entry(4'd5); wait_done();
        do_entry(4'd6); wait_done();
        do_entry(4'd7); wait_done();
        chk("count_after_3", count, 3);
        do_exit(4'd6);  wait_done();
        do_entry(4'd9); wait_done();
        do_entry(4'd5); wait_done();
        do_exit(4'd12); wait_done();
        chk("count_after_dup_err", count, 3);

        foreach (fill[i]) begin
            do_entry(4'(fill[i]));
            wait_done();
        end
        chk("full_count", count, 16);
        chk("full_flag", full, 1);
        do_entry(4'd3); wait_done();
        chk("full_after_rej", full, 1);
        do_exit(4'd3);  wait_done();
        chk("count_after_exit", count, 15);
        chk("full_cleared", full, 0);

        do_both(4'd3, 4'd7); wait_done();
        chk("count_net", count, 15);

        @(posedge clk); #1;
        bksens = 1'b1;
        vn     = 4'd11;
        @(posedge clk); #1;
        bksens = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("busy_mid_scan", busy, 1);
        rst_n = 1'b0;
        model_reset();
        #10;
        chk("abort_count", count, 0);
        chk("abort_empty", empty, 1);
        chk("abort_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_no_pulse_count", count, 0);
        do_entry(4'd5); wait_done();
        do_exit(4'd9);  wait_done();
        chk("final_count", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
